// File: rtl/fetch_stage_pipelined.sv
// IF stage: owns the PC, keeps one instruction fetch outstanding on a valid/ready imem port,
// and loads IF_ID = {fetch_pc+PC_STEP, instr} through a one-entry skid buffer.
module fetch_stage_pipelined #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [XLEN-1:0]   imem_resp_data,
  input  logic              branch_sel,
  input  logic [XLEN-1:0]   branch_in,
  input  logic              stall,
  input  logic              flush,
  output logic              if_id_valid,
  output logic [2*XLEN-1:0] IF_ID,
  output logic [1:0]        dbg_state
);

  // Request handshake: imem_req_valid/imem_req_addr are held until a cycle with imem_req_ready=1;
  // only a redirect withdraws a pending request. Responses count only while a fetch is outstanding.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   fetch_pc_q;
  logic              drop_q;
  logic              skid_valid_q;
  logic [2*XLEN-1:0] skid_q;

  logic              handshake;
  logic              resp_take;
  logic              new_valid;
  logic [2*XLEN-1:0] new_entry;

  assign handshake = (state_q == S_REQ) && imem_req_ready;
  assign resp_take = (state_q == S_WAIT) && imem_resp_valid;
  assign new_valid = resp_take && !drop_q && !branch_sel;
  assign new_entry = {fetch_pc_q + STEP, imem_resp_data};

  assign imem_req_valid = (state_q == S_REQ) && !rst;
  assign imem_req_addr  = pc_q;
  assign dbg_state      = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!skid_valid_q && !branch_sel) state_d = S_REQ;
      S_REQ: begin
        // A redirect abandons an unaccepted request; an accepted one must still be waited out.
        if (branch_sel)     state_d = handshake ? S_WAIT : S_IDLE;
        else if (handshake) state_d = S_WAIT;
      end
      S_WAIT: if (imem_resp_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      fetch_pc_q   <= '0;
      drop_q       <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      if_id_valid  <= 1'b0;
      IF_ID        <= '0;
    end else begin
      state_q <= state_d;

      if (branch_sel)     pc_q <= branch_in;
      else if (handshake) pc_q <= pc_q + STEP;

      if (handshake) fetch_pc_q <= pc_q;

      // Any fetch still owed to us after a redirect belongs to the old path.
      if (branch_sel && (handshake || (state_q == S_WAIT && !imem_resp_valid))) drop_q <= 1'b1;
      else if (resp_take)                                                       drop_q <= 1'b0;

      if (branch_sel) begin
        if_id_valid  <= 1'b0;
        skid_valid_q <= 1'b0;
      end else if (flush) begin
        skid_valid_q <= 1'b0;
        if_id_valid  <= new_valid;
        if (new_valid) IF_ID <= new_entry;
      end else if (!stall) begin
        if (skid_valid_q) begin
          IF_ID        <= skid_q;
          if_id_valid  <= 1'b1;
          skid_valid_q <= new_valid;
          if (new_valid) skid_q <= new_entry;
        end else begin
          if_id_valid <= new_valid;
          if (new_valid) IF_ID <= new_entry;
        end
      end else if (new_valid) begin
        if (!if_id_valid) begin
          IF_ID       <= new_entry;
          if_id_valid <= 1'b1;
        end else begin
          skid_q       <= new_entry;
          skid_valid_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage_pipelined.sv
// Bench for fetch_stage_pipelined: directed scenarios plus random traffic, checked every cycle
// against a queue model of IF_ID+skid and a model PC.
module tb_fetch_stage_pipelined;

  localparam logic [31:0] RST_PC  = 32'h40;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        branch_sel = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] branch_in = '0;
  logic        if_id_valid;
  logic [63:0] IF_ID;
  logic [1:0]  dbg_state;

  fetch_stage_pipelined #(.XLEN(32), .RESET_PC(RST_PC), .PC_STEP(4)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .branch_sel(branch_sel), .branch_in(branch_in), .stall(stall), .flush(flush),
    .if_id_valid(if_id_valid), .IF_ID(IF_ID), .dbg_state(dbg_state)
  );

  // Second instance for PC wrap from reset, always-ready 1-cycle memory, never stalled.
  logic        w_req_valid, w_resp_valid = 1'b0, w_if_id_valid;
  logic [31:0] w_req_addr, w_resp_data = '0;
  logic [63:0] w_IF_ID;
  logic [1:0]  w_dbg_state;
  logic        w_one = 1'b1, w_zero = 1'b0;
  logic [31:0] w_zero32 = '0;

  fetch_stage_pipelined #(.XLEN(32), .RESET_PC(WRAP_PC), .PC_STEP(4)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_one), .imem_req_addr(w_req_addr),
    .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
    .branch_sel(w_zero), .branch_in(w_zero32), .stall(w_zero), .flush(w_zero),
    .if_id_valid(w_if_id_valid), .IF_ID(w_IF_ID), .dbg_state(w_dbg_state)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) begin
    w_resp_valid <= w_req_valid;
    w_resp_data  <= mem_word(w_req_addr);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: fetch PC, IF_ID+skid contents in delivery order, and the one outstanding fetch.
  logic [31:0] m_pc = RST_PC;
  logic [63:0] exp_q[$];
  bit          out_pend  = 1'b0;
  bit          out_stale = 1'b0;
  logic [31:0] out_addr  = '0;
  int          out_cnt   = 0;
  int          lat_min   = 1;
  int          lat_max   = 1;
  bit          junk_resp = 1'b0;

  task automatic cycle(input bit r, input bit br, input logic [31:0] tgt,
                       input bit fl, input bit st, input bit rdy);
    bit          hs, hit, deliver;
    logic [31:0] a_s;
    logic [63:0] entry;
    @(negedge clk);
    rst = r; branch_sel = br; branch_in = tgt; flush = fl; stall = st; imem_req_ready = rdy;
    if (out_pend && out_cnt == 1) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(out_addr);
    end else begin
      imem_resp_valid = junk_resp;
      imem_resp_data  = 32'hDEAD_BEEF;
    end
    #1;
    hs  = imem_req_valid && imem_req_ready;
    a_s = imem_req_addr;
    if (imem_req_valid) check("req_addr", a_s, m_pc);
    if (exp_q.size() == 2) check("no_req_while_skid_full", imem_req_valid, 1'b0);
    hit   = imem_resp_valid && out_pend;
    entry = {out_addr + 32'd4, mem_word(out_addr)};
    @(posedge clk);
    if (r) begin
      m_pc     = RST_PC;
      exp_q.delete();
      out_pend = 1'b0;
    end else begin
      deliver = hit && !out_stale && !br;
      if (hit)           out_pend = 1'b0;
      else if (out_pend) out_cnt--;
      if (br) begin
        exp_q.delete();
        if (out_pend) out_stale = 1'b1;
      end else if (fl) begin
        exp_q.delete();
        if (deliver) exp_q.push_back(entry);
      end else begin
        if (!st && exp_q.size() > 0) void'(exp_q.pop_front());
        if (deliver) exp_q.push_back(entry);
      end
      if (hs) begin
        out_pend  = 1'b1;
        out_addr  = a_s;
        out_stale = br;
        out_cnt   = $urandom_range(lat_max, lat_min);
      end
      if (br)      m_pc = tgt;
      else if (hs) m_pc = m_pc + 32'd4;
    end
    #1;
    check("if_id_valid", if_id_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) check("if_id", IF_ID, exp_q[0]);
  endtask

  task automatic idle_cycle(input bit st);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, st, 1'b1);
  endtask

  initial begin
    // Reset, with a stray response during reset and right after it.
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    junk_resp = 1'b1;
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("rst_if_id_zero", IF_ID, 64'h0);
    check("rst_if_id_valid", if_id_valid, 1'b0);
    check("rst_state_idle", dbg_state, 2'd0);
    idle_cycle(1'b0);
    junk_resp = 1'b0;
    check("first_req_valid", imem_req_valid, 1'b1);
    check("first_req_addr", imem_req_addr, 32'h40);
    check("wrap_first_addr", w_req_addr, WRAP_PC);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    check("first_if_id_latency", if_id_valid, 1'b1);
    check("first_if_id", IF_ID, {32'h44, mem_word(32'h40)});
    check("wrap_if_id_valid", w_if_id_valid, 1'b1);
    check("wrap_if_id_upper", w_IF_ID[63:32], 64'h0);
    check("wrap_if_id_instr", w_IF_ID[31:0], mem_word(WRAP_PC));
    idle_cycle(1'b0);
    check("wrap_next_req_valid", w_req_valid, 1'b1);
    check("wrap_next_req_addr", w_req_addr, 32'h0);

    // Streaming with a 1-cycle memory.
    for (int i = 0; i < 15; i++) idle_cycle(1'b0);

    // Stall while streaming: skid fills and requests stop.
    for (int i = 0; i < 10 && !if_id_valid; i++) idle_cycle(1'b0);
    check("stall_start_valid", if_id_valid, 1'b1);
    for (int i = 0; i < 5; i++) idle_cycle(1'b1);
    check("stall_hold_valid", if_id_valid, 1'b1);
    check("stall_req_stopped", imem_req_valid, 1'b0);
    for (int i = 0; i < 8; i++) idle_cycle(1'b0);

    // Redirect while waiting on a slow response.
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 10 && !out_pend; i++) idle_cycle(1'b0);
    check("redir_wait_reached", dbg_state, 2'd2);
    cycle(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 30 && !if_id_valid; i++) idle_cycle(1'b0);
    check("redir_if_id", IF_ID, {32'h104, mem_word(32'h100)});

    // Flush and redirect together under stall.
    lat_min = 1; lat_max = 2;
    for (int i = 0; i < 20 && !if_id_valid; i++) idle_cycle(1'b1);
    check("flushbr_pre_valid", if_id_valid, 1'b1);
    cycle(1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
    check("flushbr_if_id_valid", if_id_valid, 1'b0);
    for (int i = 0; i < 20 && !imem_req_valid; i++) idle_cycle(1'b0);
    check("flushbr_req_addr", imem_req_addr, 32'h200);

    // Reset while a slow fetch is outstanding; its late response is ignored.
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 20 && !out_pend; i++) idle_cycle(1'b0);
    idle_cycle(1'b0);
    junk_resp = 1'b1;
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle_cycle(1'b0);
    junk_resp = 1'b0;
    check("late_resp_ignored", if_id_valid, 1'b0);
    check("post_rst_req_addr", imem_req_addr, RST_PC);

    // Random traffic.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 2000; i++) begin
      bit          r, br, fl, st, rdy;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 199) == 0);
      br  = ($urandom_range(0, 19) == 0);
      fl  = ($urandom_range(0, 19) == 0);
      st  = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      cycle(r, br, tgt, fl, st, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
